// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared register-bus widths and grant encoding for the writeback arbiter
package wb_arbiter_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  typedef enum logic {
    GRANT_R0 = 1'b0,
    GRANT_R1 = 1'b1
  } grant_e;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - per-requester (addr, data) write queue with occupancy and pending-address match
module wb_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] match_addr_a_i,
  input  logic [ADDR_W-1:0] match_addr_b_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W-1:0] head_addr_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic              match_a_o,
  output logic              match_b_o
);

  localparam int PW = $clog2(DEPTH);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [PW:0]       count_q;
  logic              wr_en, rd_en;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign wr_en   = push_i && !full_o;
  assign rd_en   = pop_i && !empty_o;

  assign head_addr_o = addr_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];

  // Storage needs no reset: only slots inside the live window are ever observed.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      addr_q[wr_ptr_q] <= push_addr_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    logic [PW-1:0] ofs;
    ofs       = '0;
    match_a_o = 1'b0;
    match_b_o = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      ofs = PW'(j) - rd_ptr_q;
      if ({1'b0, ofs} < count_q) begin
        if (addr_q[j] == match_addr_a_i) match_a_o = 1'b1;
        if (addr_q[j] == match_addr_b_i) match_b_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin merge of two queued register-file writers onto one write port
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DATA_W     = RegBus,
  parameter int ADDR_W     = RegAddrBus,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_data,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_data,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] qaddr1,
  input  logic [ADDR_W-1:0] qaddr2,
  output logic              qhit1,
  output logic              qhit2
);

  logic              full0, empty0, full1, empty1;
  logic [ADDR_W-1:0] head_addr0, head_addr1;
  logic [DATA_W-1:0] head_data0, head_data1;
  logic              m0_a, m0_b, m1_a, m1_b;
  logic              gnt0, gnt1;
  grant_e            last_grant_q, last_grant_d;

  assign r0_ready = !full0;
  assign r1_ready = !full1;

  wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk_i(clk), .rst_ni(rst),
    .push_i(r0_valid), .push_addr_i(r0_addr), .push_data_i(r0_data),
    .pop_i(gnt0), .match_addr_a_i(qaddr1), .match_addr_b_i(qaddr2),
    .full_o(full0), .empty_o(empty0),
    .head_addr_o(head_addr0), .head_data_o(head_data0),
    .match_a_o(m0_a), .match_b_o(m0_b)
  );

  wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk_i(clk), .rst_ni(rst),
    .push_i(r1_valid), .push_addr_i(r1_addr), .push_data_i(r1_data),
    .pop_i(gnt1), .match_addr_a_i(qaddr1), .match_addr_b_i(qaddr2),
    .full_o(full1), .empty_o(empty1),
    .head_addr_o(head_addr1), .head_data_o(head_data1),
    .match_a_o(m1_a), .match_b_o(m1_b)
  );

  // On a tie the requester not served last wins; addr-0 pops still count as grants.
  always_comb begin
    gnt0         = !empty0 && (empty1 || last_grant_q == GRANT_R1);
    gnt1         = !empty1 && !gnt0;
    last_grant_d = last_grant_q;
    if (gnt0)      last_grant_d = GRANT_R0;
    else if (gnt1) last_grant_d = GRANT_R1;
  end

  always_comb begin
    waddr = '0;
    wdata = '0;
    if (gnt0) begin
      waddr = head_addr0;
      wdata = head_data0;
    end else if (gnt1) begin
      waddr = head_addr1;
      wdata = head_data1;
    end
    we = (gnt0 || gnt1) && (waddr != '0);
  end

  assign qhit1 = (qaddr1 != '0) && (m0_a || m1_a);
  assign qhit2 = (qaddr2 != '0) && (m0_b || m1_b);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_grant_q <= GRANT_R1;
    else      last_grant_q <= last_grant_d;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r0_valid, r1_valid, r0_ready, r1_ready;
  logic [4:0]  r0_addr, r1_addr, waddr, qaddr1, qaddr2;
  logic [31:0] r0_data, r1_data, wdata;
  logic        we, qhit1, qhit2;

  int errors = 0;
  int checks = 0;

  wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr), .r0_data(r0_data),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr), .r1_data(r1_data),
    .we(we), .waddr(waddr), .wdata(wdata),
    .qaddr1(qaddr1), .qaddr2(qaddr2), .qhit1(qhit1), .qhit2(qhit2)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    r0_valid = 1'b0; r0_addr = '0; r0_data = '0;
    r1_valid = 1'b0; r1_addr = '0; r1_data = '0;
  endtask

  task automatic apply_reset;
    rst = 1'b0;
    idle_inputs();
    qaddr1 = '0;
    qaddr2 = '0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset;
    idle_inputs();
    qaddr1 = 5'd3;
    qaddr2 = 5'd0;
    #1 rst = 1'b0;
    #2;
    checks++; if (we !== 1'b0)        begin errors++; $display("FAIL reset_we: got %b expected 0", we); end
    checks++; if (waddr !== 5'd0)     begin errors++; $display("FAIL reset_waddr: got %0d expected 0", waddr); end
    checks++; if (wdata !== 32'd0)    begin errors++; $display("FAIL reset_wdata: got %h expected 0", wdata); end
    checks++; if (r0_ready !== 1'b1)  begin errors++; $display("FAIL reset_r0_ready: got %b expected 1", r0_ready); end
    checks++; if (r1_ready !== 1'b1)  begin errors++; $display("FAIL reset_r1_ready: got %b expected 1", r1_ready); end
    checks++; if (qhit1 !== 1'b0)     begin errors++; $display("FAIL reset_qhit1: got %b expected 0", qhit1); end
    checks++; if (qhit2 !== 1'b0)     begin errors++; $display("FAIL reset_qhit2: got %b expected 0", qhit2); end
    tick();
    rst = 1'b1;
    qaddr1 = '0;
  endtask

  task automatic test_single_write;
    apply_reset();
    r0_valid = 1'b1; r0_addr = 5'd3; r0_data = 32'h1234_5678;
    qaddr1 = 5'd3;
    tick();
    r0_valid = 1'b0;
    checks++; if (we !== 1'b1)            begin errors++; $display("FAIL single_we: got %b expected 1", we); end
    checks++; if (waddr !== 5'd3)         begin errors++; $display("FAIL single_waddr: got %0d expected 3", waddr); end
    checks++; if (wdata !== 32'h1234_5678) begin errors++; $display("FAIL single_wdata: got %h expected 12345678", wdata); end
    checks++; if (qhit1 !== 1'b1)         begin errors++; $display("FAIL single_qhit1_head: got %b expected 1", qhit1); end
    tick();
    checks++; if (we !== 1'b0)            begin errors++; $display("FAIL single_we_after: got %b expected 0", we); end
    checks++; if (waddr !== 5'd0)         begin errors++; $display("FAIL single_waddr_after: got %0d expected 0", waddr); end
    checks++; if (qhit1 !== 1'b0)         begin errors++; $display("FAIL single_qhit1_after: got %b expected 0", qhit1); end
    qaddr1 = '0;
  endtask

  task automatic test_round_robin;
    int i0, i1;
    logic rd0, rd1;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    i0 = 0; i1 = 0;
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      r0_valid = 1'b1; r0_addr = 5'(8 + i0);  r0_data = 32'hA000_0000 + 32'(i0);
      r1_valid = 1'b1; r1_addr = 5'(16 + i1); r1_data = 32'hB000_0000 + 32'(i1);
      rd0 = r0_ready; rd1 = r1_ready;
      tick();
      if (rd0) i0++;
      if (rd1) i1++;
      exp_addr = (c % 2 == 0) ? 5'(8 + c / 2) : 5'(16 + c / 2);
      exp_data = (c % 2 == 0) ? 32'hA000_0000 + 32'(c / 2) : 32'hB000_0000 + 32'(c / 2);
      checks++;
      if (we !== 1'b1 || waddr !== exp_addr || wdata !== exp_data) begin
        errors++;
        $display("FAIL rr_grant%0d: got we=%b addr=%0d data=%h expected we=1 addr=%0d data=%h",
                 c, we, waddr, wdata, exp_addr, exp_data);
      end
    end
    idle_inputs();
  endtask

  task automatic test_backpressure;
    int i0;
    logic rd0;
    logic       r1v  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [4:0] r1a  [6] = '{5'd20, 5'd21, 5'd30, 5'd0, 5'd0, 5'd0};
    logic [4:0] expa [6] = '{5'd1, 5'd20, 5'd2, 5'd21, 5'd3, 5'd4};
    logic       expr [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      r1_valid = 1'b1; r1_addr = 5'(10 + c); r1_data = 32'hC000_0000 + 32'(c);
      checks++; if (r1_ready !== 1'b1) begin errors++; $display("FAIL bp_solo_ready%0d: got %b expected 1", c, r1_ready); end
      tick();
      checks++;
      if (we !== 1'b1 || waddr !== 5'(10 + c)) begin
        errors++; $display("FAIL bp_solo_grant%0d: got we=%b addr=%0d expected we=1 addr=%0d", c, we, waddr, 10 + c);
      end
    end
    apply_reset();
    i0 = 0;
    for (int c = 0; c < 6; c++) begin
      r0_valid = 1'b1; r0_addr = 5'(1 + i0); r0_data = 32'(i0);
      r1_valid = r1v[c]; r1_addr = r1a[c]; r1_data = 32'hD000_0000 + 32'(c);
      rd0 = r0_ready;
      tick();
      if (rd0) i0++;
      checks++;
      if (we !== 1'b1 || waddr !== expa[c]) begin
        errors++; $display("FAIL bp_grant%0d: got we=%b addr=%0d expected we=1 addr=%0d", c, we, waddr, expa[c]);
      end
      checks++;
      if (r1_ready !== expr[c]) begin
        errors++; $display("FAIL bp_r1_ready%0d: got %b expected %b", c, r1_ready, expr[c]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_zero_addr;
    apply_reset();
    r0_valid = 1'b1; r0_addr = 5'd0; r0_data = 32'hFFFF_FFFF;
    qaddr1 = 5'd0;
    tick();
    r0_addr = 5'd5; r0_data = 32'h0000_0055;
    checks++; if (we !== 1'b0)    begin errors++; $display("FAIL zero_we: got %b expected 0", we); end
    checks++; if (waddr !== 5'd0) begin errors++; $display("FAIL zero_waddr: got %0d expected 0", waddr); end
    checks++; if (qhit1 !== 1'b0) begin errors++; $display("FAIL zero_qhit1: got %b expected 0", qhit1); end
    tick();
    r0_valid = 1'b0;
    checks++;
    if (we !== 1'b1 || waddr !== 5'd5 || wdata !== 32'h55) begin
      errors++; $display("FAIL zero_next: got we=%b addr=%0d data=%h expected we=1 addr=5 data=55", we, waddr, wdata);
    end
    tick();
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL zero_drained: got %b expected 0", we); end
    idle_inputs();
  endtask

  task automatic test_pending_hit;
    apply_reset();
    r0_valid = 1'b1; r0_addr = 5'd2; r0_data = 32'h22;
    r1_valid = 1'b1; r1_addr = 5'd7; r1_data = 32'h77;
    qaddr1 = 5'd2; qaddr2 = 5'd7;
    tick();
    r0_addr = 5'd3; r0_data = 32'h33;
    r1_valid = 1'b0;
    checks++; if (waddr !== 5'd2) begin errors++; $display("FAIL hit_c1_waddr: got %0d expected 2", waddr); end
    checks++; if (qhit2 !== 1'b1) begin errors++; $display("FAIL hit_c1_qhit2: got %b expected 1", qhit2); end
    checks++; if (qhit1 !== 1'b1) begin errors++; $display("FAIL hit_c1_qhit1: got %b expected 1", qhit1); end
    tick();
    r0_valid = 1'b0;
    checks++; if (waddr !== 5'd7 || we !== 1'b1) begin errors++; $display("FAIL hit_c2_grant: got we=%b addr=%0d expected we=1 addr=7", we, waddr); end
    checks++; if (qhit2 !== 1'b1) begin errors++; $display("FAIL hit_c2_qhit2: got %b expected 1", qhit2); end
    checks++; if (qhit1 !== 1'b0) begin errors++; $display("FAIL hit_c2_qhit1: got %b expected 0", qhit1); end
    tick();
    checks++; if (waddr !== 5'd3) begin errors++; $display("FAIL hit_c3_waddr: got %0d expected 3", waddr); end
    checks++; if (qhit2 !== 1'b0) begin errors++; $display("FAIL hit_c3_qhit2: got %b expected 0", qhit2); end
    qaddr1 = '0; qaddr2 = '0;
  endtask

  task automatic test_reset_mid;
    apply_reset();
    r0_valid = 1'b1; r0_addr = 5'd11; r0_data = 32'h11;
    r1_valid = 1'b1; r1_addr = 5'd12; r1_data = 32'h12;
    tick();
    r0_addr = 5'd13; r0_data = 32'h13;
    r1_addr = 5'd14; r1_data = 32'h14;
    tick();
    idle_inputs();
    qaddr1 = 5'd13; qaddr2 = 5'd14;
    checks++; if (r1_ready !== 1'b0) begin errors++; $display("FAIL mid_pre_full: got r1_ready=%b expected 0", r1_ready); end
    #2 rst = 1'b0;
    #1;
    checks++; if (we !== 1'b0)       begin errors++; $display("FAIL mid_we: got %b expected 0", we); end
    checks++; if (waddr !== 5'd0)    begin errors++; $display("FAIL mid_waddr: got %0d expected 0", waddr); end
    checks++; if (wdata !== 32'd0)   begin errors++; $display("FAIL mid_wdata: got %h expected 0", wdata); end
    checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b%b expected 11", r0_ready, r1_ready); end
    checks++; if (qhit1 !== 1'b0 || qhit2 !== 1'b0) begin errors++; $display("FAIL mid_qhit: got %b%b expected 00", qhit1, qhit2); end
    tick();
    #2 rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (we !== 1'b0 || waddr !== 5'd0) begin
        errors++; $display("FAIL mid_after%0d: got we=%b addr=%0d expected we=0 addr=0", c, we, waddr);
      end
    end
    qaddr1 = '0; qaddr2 = '0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_backpressure();
    test_zero_addr();
    test_pending_hit();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width (matches RegBus).
REQ-002 SHALL have parameter ADDR_W, default 5, register address width (matches RegAddrBus).
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, entries per requester queue, power of two, >=2.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-006 SHALL have ports r0_valid/r1_valid  input  1  requester 0 (pipeline writeback) / requester 1 (multi-cycle unit) write request.
REQ-007 SHALL have ports r0_ready/r1_ready  output  1  requester queue can accept.
REQ-008 SHALL have ports r0_addr/r1_addr  input  ADDR_W  destination register.
REQ-009 SHALL have ports r0_data/r1_data  input  DATA_W  write data.
REQ-010 SHALL have ports we  output  1,  waddr  output  ADDR_W,  wdata  output  DATA_W: regfile write port.
REQ-011 SHALL have ports qaddr1/qaddr2  input  ADDR_W  decode-stage source addresses to check.
REQ-012 SHALL have ports qhit1/qhit2  output  1  queued, unretired write to that address exists.

Function
REQ-013 SHALL hold one FIFO_DEPTH-entry FIFO (addr, data) per requester.
REQ-014 SHALL drive rN_ready = 1 iff FIFO N holds fewer than FIFO_DEPTH entries; readiness never depends on same-cycle pop.
REQ-015 SHALL push on rising edge when rN_valid && rN_ready; rN_valid while not ready SHALL be ignored, requester holds.
REQ-016 SHALL make a pushed entry eligible for grant on the next cycle; minimum latency push-edge to we high = 1 cycle.
REQ-017 SHALL grant at most one FIFO head per cycle; grant pops that head on the following edge.
REQ-018 SHALL arbitrate round-robin: if only one FIFO non-empty, grant it; if both, grant the one not granted last; last_grant register updates on every grant.
REQ-019 SHALL drive we/waddr/wdata combinationally from granted head; with no grant we=0, waddr=0, wdata=0.
REQ-020 SHALL pop entries with addr 0 on grant with we=0 (regfile r0 never written); such pops count for round-robin.
REQ-021 SHALL allow push and pop on same FIFO in one cycle; occupancy unchanged, FIFO order kept.
REQ-022 SHALL keep per-FIFO read/write pointers wrapping modulo FIFO_DEPTH plus occupancy count 0..FIFO_DEPTH.
REQ-023 SHALL set qhitK = 1 iff qaddrK != 0 and any valid entry in either FIFO (including the head granted this cycle) has addr == qaddrK; purely combinational.
REQ-024 SHALL not reorder writes within one requester; no ordering guarantee across requesters.

Reset
REQ-025 SHALL, while rst=0, asynchronously empty both FIFOs, set last_grant=1 (requester 0 wins first tie), giving we=0, waddr=0, wdata=0, r0_ready=r1_ready=1, qhit1=qhit2=0.
REQ-026 SHALL discard queued writes on reset mid-operation; no partial write issued after reset deassertion.
REQ-027 SHALL not require clock edges for reset to take effect; first push accepted on first rising edge with rst=1.

Structure
REQ-028 SHALL take DATA_W/ADDR_W defaults from shared defines (RegBus, RegAddrBus, RegNumLog2, WriteEnable); no new shared constants.
REQ-029 SHALL instantiate two copies of sub-module wb_fifo (synchronous FIFO with count, full/empty, head and entry-match outputs); arbitration, last_grant and hit logic stay in wb_arbiter.

Verification
REQ-030 SHALL verify single write: r0 pushes (addr 3, 0x1234_5678) cycle 0 -> cycle 1 we=1, waddr=3, wdata=0x1234_5678; cycle 2 we=0.
REQ-031 SHALL verify round-robin: both push every cycle after reset -> grants alternate r0, r1, r0, r1; r0 first.
REQ-032 SHALL verify full/backpressure: r1 pushes 3 entries with no r0 traffic while grants occur -> r1_ready stays 1 (push+pop same cycle); with r0 continuously queued, r1 fills to 2 and r1_ready=0 until popped.
REQ-033 SHALL verify r0 write: r0 pushes (addr 0, 0xFFFF_FFFF) -> entry consumed next cycle with we=0; qaddr1=0 -> qhit1=0.
REQ-034 SHALL verify pending hit: r1 queues addr 7 while r0 queue busy -> qaddr2=7 gives qhit2=1 until cycle its write issues, 0 afterwards.
REQ-035 SHALL verify reset mid-operation: both FIFOs full, rst=0 between edges -> we=0 immediately, readies=1, no queued write appears after rst=1.
